// File: rtl/pll_reset_ce_gen.sv
// pll_reset_ce_gen
//   Sits downstream of the core PLL in the clk_sys domain. Synchronizes the
//   asynchronous PLL lock flag and holds the core in reset until lock has been
//   stable for LOCK_HOLD cycles. Once running, it produces phase-aligned
//   single-cycle enables for pixel and CPU logic. Any loss of lock drops the
//   core straight back into reset.
//
// Ports:
//   clk_sys       in   core clock (PLL output)
//   reset         in   synchronous active-high core reset (OSD/user reset)
//   pll_locked    in   PLL lock flag, asynchronous to clk_sys
//   core_reset    out  registered active-high reset for downstream logic
//   ce_pix        out  registered single-cycle pixel enable
//   ce_cpu        out  registered single-cycle CPU enable
//   ready         out  high while the generator is running
//   lock_loss_cnt out  [7:0] saturating count of lock losses while running
//                      (present only when PLL_RESET_LOSS_CNT_EN is defined)
//
// Optional feature macro: PLL_RESET_LOSS_CNT_EN
module pll_reset_ce_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_HOLD   = 1024,
  parameter int CE_PIX_DIV  = 3,
  parameter int CE_CPU_DIV  = 6
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       core_reset,
  output logic       ce_pix,
  output logic       ce_cpu,
  output logic       ready
`ifdef PLL_RESET_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int HOLD_W = (LOCK_HOLD  > 1) ? $clog2(LOCK_HOLD)  : 1;
  localparam int PIX_W  = (CE_PIX_DIV > 1) ? $clog2(CE_PIX_DIV) : 1;
  localparam int CPU_W  = (CE_CPU_DIV > 1) ? $clog2(CE_CPU_DIV) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(CE_PIX_DIV - 1);
  localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CE_CPU_DIV - 1);

  // Reject illegal configurations at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pll_reset_ce_gen: SYNC_STAGES must be 2..4");
  end
  if (LOCK_HOLD < 1 || LOCK_HOLD > 65535) begin : g_bad_hold
    $error("pll_reset_ce_gen: LOCK_HOLD must be 1..65535");
  end
  if (CE_PIX_DIV < 2) begin : g_bad_pix
    $error("pll_reset_ce_gen: CE_PIX_DIV must be >= 2");
  end
  if (CE_CPU_DIV < CE_PIX_DIV || (CE_CPU_DIV % CE_PIX_DIV) != 0) begin : g_bad_cpu
    $error("pll_reset_ce_gen: CE_CPU_DIV must be a multiple of CE_PIX_DIV");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [PIX_W-1:0]       pix_q;
  logic [CPU_W-1:0]       cpu_q;
  logic                   run_active;

  // Lock flag synchronizer; the last stage is the only one the logic reads.
  always_ff @(posedge clk_sys) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lk_s = sync_q[SYNC_STAGES-1];

  // A RUN cycle only counts as running if lock is still present; a lost lock
  // must suppress the enable in the same cycle core_reset reasserts.
  assign run_active = (state_q == RUN) && lk_s;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // The hold counter only survives while in HOLD with lock present, so any
  // dropout restarts the qualification window from zero.
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    case (state_q)
      WAIT_LOCK: begin
        if (lk_s) state_d = HOLD;
      end
      HOLD: begin
        if (!lk_s)                  state_d = WAIT_LOCK;
        else if (hold_q == HOLD_LAST) state_d = RUN;
        else                        hold_d  = hold_q + 1'b1;
      end
      RUN: begin
        if (!lk_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Both dividers sit at zero outside RUN so the first running cycle emits
  // aligned pix and cpu enables.
  always_ff @(posedge clk_sys) begin
    if (reset || !run_active) begin
      pix_q <= '0;
      cpu_q <= '0;
    end else begin
      pix_q <= (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
      cpu_q <= (cpu_q == CPU_LAST) ? '0 : cpu_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      core_reset <= 1'b1;
      ce_pix     <= 1'b0;
      ce_cpu     <= 1'b0;
      ready      <= 1'b0;
    end else begin
      core_reset <= !run_active;
      ready      <= run_active;
      ce_pix     <= run_active && (pix_q == '0);
      ce_cpu     <= run_active && (cpu_q == '0);
    end
  end

`ifdef PLL_RESET_LOSS_CNT_EN
  // Counts only lock losses out of RUN; aborted HOLD windows are not losses.
  always_ff @(posedge clk_sys) begin
    if (reset)
      lock_loss_cnt <= 8'd0;
    else if ((state_q == RUN) && !lk_s && (lock_loss_cnt != 8'd255))
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// tb_pll_reset_ce_gen
//   Directed bench for pll_reset_ce_gen with LOCK_HOLD=16, SYNC_STAGES=2 and
//   default enable dividers. Edge numbers count clk_sys rising edges from 1.
module tb_pll_reset_ce_gen;

  localparam int LH = 16;

  logic clk_sys = 1'b0;
  logic reset;
  logic pll_locked;
  logic core_reset, ce_pix, ce_cpu, ready;
`ifdef PLL_RESET_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int edge_num    = 0;
  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic rst;
    logic lk;
    logic exp_core_reset;
    logic exp_ce_pix;
    logic exp_ce_cpu;
    logic exp_ready;
  } vec_t;

  vec_t tab [1:40];

  pll_reset_ce_gen #(
    .SYNC_STAGES(2),
    .LOCK_HOLD  (LH),
    .CE_PIX_DIV (3),
    .CE_CPU_DIV (6)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pll_locked(pll_locked),
    .core_reset(core_reset),
    .ce_pix    (ce_pix),
    .ce_cpu    (ce_cpu),
    .ready     (ready)
`ifdef PLL_RESET_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic applyStimulus(input logic r, input logic l);
    reset      = r;
    pll_locked = l;
    @(posedge clk_sys);
    #1;
    edge_num++;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", name, edge_num, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic cr, input logic px,
                          input logic cp, input logic rd);
    checkOutput({tag, ".core_reset"}, {7'd0, core_reset}, {7'd0, cr});
    checkOutput({tag, ".ce_pix"},     {7'd0, ce_pix},     {7'd0, px});
    checkOutput({tag, ".ce_cpu"},     {7'd0, ce_cpu},     {7'd0, cp});
    checkOutput({tag, ".ready"},      {7'd0, ready},      {7'd0, rd});
  endtask

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b0;

    // Power-up: reset on edges 1-2, lock sampled high from edge 5, so release
    // lands on edge 5+2+16+1=24; pix every 3 edges and cpu every 6 thereafter.
    for (int i = 1; i <= 40; i++) begin
      tab[i].rst            = (i <= 2);
      tab[i].lk             = (i >= 5);
      tab[i].exp_core_reset = (i < 24);
      tab[i].exp_ready      = (i >= 24);
      tab[i].exp_ce_pix     = (i >= 24) && (((i - 24) % 3) == 0);
      tab[i].exp_ce_cpu     = (i >= 24) && (((i - 24) % 6) == 0);
    end

    $display("[TB] power-up and steady run");
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(tab[i].rst, tab[i].lk);
      checkAll("pwrup", tab[i].exp_core_reset, tab[i].exp_ce_pix,
               tab[i].exp_ce_cpu, tab[i].exp_ready);
    end

    // Lock lost in RUN: first low sample at edge 41, reset back at edge 43.
    $display("[TB] lock loss during run");
    applyStimulus(1'b0, 1'b0);
    checkOutput("loss_e41.core_reset", {7'd0, core_reset}, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("loss_e42.core_reset", {7'd0, core_reset}, 8'd0);
    checkOutput("loss_e42.ready", {7'd0, ready}, 8'd1);
`ifdef PLL_RESET_LOSS_CNT_EN
    checkOutput("loss_e42.cnt", lock_loss_cnt, 8'd0);
`endif
    applyStimulus(1'b0, 1'b0);
    checkAll("loss_e43", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef PLL_RESET_LOSS_CNT_EN
    checkOutput("loss_e43.cnt", lock_loss_cnt, 8'd1);
`endif

    // HOLD abort: lock high 44-54 (hold count reaches 10 at edge 56), low
    // 55-59, high again from 60, so release only at 60+2+16+1=79.
    $display("[TB] hold abort and restart");
    while (edge_num < 78) begin
      applyStimulus(1'b0, !(edge_num + 1 >= 55 && edge_num + 1 <= 59));
      checkOutput("abort.core_reset", {7'd0, core_reset}, 8'd1);
      checkOutput("abort.ce_pix", {7'd0, ce_pix}, 8'd0);
    end
    applyStimulus(1'b0, 1'b1);
    checkAll("abort_e79", 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef PLL_RESET_LOSS_CNT_EN
    checkOutput("abort.cnt", lock_loss_cnt, 8'd1);
`endif

    // User reset in RUN at edge 86; lock first re-sampled at 87, release 106.
    $display("[TB] reset during run");
    while (edge_num < 85) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkAll("rst_e86", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef PLL_RESET_LOSS_CNT_EN
    checkOutput("rst_e86.cnt", lock_loss_cnt, 8'd0);
`endif
    while (edge_num < 105) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("rst_hold.core_reset", {7'd0, core_reset}, 8'd1);
    end
    applyStimulus(1'b0, 1'b1);
    checkAll("rst_e106", 1'b0, 1'b1, 1'b1, 1'b1);

`ifdef PLL_RESET_LOSS_CNT_EN
    // 300 lock-loss events from RUN: counter must saturate at 255.
    $display("[TB] lock loss counter saturation");
    for (int ev = 0; ev < 300; ev++) begin
      int waited;
      waited = 0;
      while (core_reset !== 1'b0 && waited < 40) begin
        applyStimulus(1'b0, 1'b1);
        waited++;
      end
      if (core_reset !== 1'b0) begin
        checkOutput("sat.release_timeout", {7'd0, core_reset}, 8'd0);
        break;
      end
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
    end
    checkOutput("sat.cnt", lock_loss_cnt, 8'd255);
    applyStimulus(1'b1, 1'b0);
    checkOutput("sat.cnt_after_reset", lock_loss_cnt, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
